mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter BIT_W, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have parameter SWAP_ENDIAN, default 1; 1 byte-reverses cache data in both directions, 0 passes it through.
REQ-003 SHALL have parameter FORWARD_EN, default 1; 1 drives the fwd_* outputs, 0 ties them to 0.
REQ-004 SHALL have ports: clk input 1, clock; rst_n input 1, reset (asynchronous, active-low).
REQ-005 SHALL have ports: alu_result_in input BIT_W, effective address or ALU value; mem_wdata_in input BIT_W, store source.
REQ-006 SHALL have ports: memrd_in input 1, load; memwr_in input 1, store; funct3_in input 3, access size/sign.
REQ-007 SHALL have ports: PC_plus_4_in input BIT_W; rd_in input 5; mem2reg_in input 1; regwr_in input 1 (transparent).
REQ-008 SHALL have ports: alu_result_out, mem_dat, PC_plus_4_out output BIT_W; rd_out output 5; mem2reg_out, regwr_out output 1.
REQ-009 SHALL have ports: stall_o output 1, freeze upstream; misalign_o output 1, registered misaligned-access flag.
REQ-010 SHALL have ports: fwd_valid output 1, fwd_rd output 5, fwd_data output BIT_W (MEM/WB bypass).
REQ-011 SHALL have ports: DCACHE_stall input 1; DCACHE_ren, DCACHE_wen output 1; DCACHE_addr output 30 (word address); DCACHE_be output 4; DCACHE_rdata input 32; DCACHE_wdata output 32.

Function
REQ-012 SHALL decode funct3: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; stores use size bits [1:0] only.
REQ-013 SHALL flag misaligned when half with addr[0]=1, or word with addr[1:0]!=0; other funct3 codes are treated as word.
REQ-014 SHALL suppress DCACHE_ren/wen for misaligned accesses; misalign_o=1, regwr_out=0 in the next cycle; no stall.
REQ-015 SHALL drive DCACHE_addr=alu_result_in[31:2] and DCACHE_ren/wen from memrd_in/memwr_in, combinationally, in IDLE and WAIT.
REQ-016 SHALL set DCACHE_be as lane mask in little-endian lane order: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111; 0000 when no store.
REQ-017 SHALL replicate store data into lanes (byte x4, half x2), then byte-reverse when SWAP_ENDIAN=1.
REQ-018 SHALL implement FSM IDLE/WAIT: IDLE->WAIT when aligned access and DCACHE_stall=1; WAIT->IDLE when DCACHE_stall=0; non-access instructions never enter WAIT.
REQ-019 SHALL assert stall_o = (aligned access) & DCACHE_stall, combinationally, in both states.
REQ-020 SHALL hold ren/wen, address, be and wdata stable while stall_o=1 (guaranteed by frozen inputs).
REQ-021 SHALL, on stall_o=1, load a bubble into MEM/WB (regwr_out=0, mem2reg_out=0, misalign_o=0); other outputs don't-care.
REQ-022 SHALL, on stall_o=0, register all pass-through fields one cycle after input (latency 1).
REQ-023 SHALL extract load data: un-swap, select lane by addr[1:0], sign/zero extend per funct3, register into mem_dat in the completing cycle.
REQ-024 SHALL drive fwd_valid=regwr_out & (rd_out!=0); fwd_rd=rd_out; fwd_data=mem2reg_out?mem_dat:alu_result_out.
REQ-025 SHALL give misalign priority over DCACHE_stall when both occur in one cycle.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously return FSM to IDLE and clear all registered outputs to 0.
REQ-027 SHALL, on reset during WAIT, drop stall_o once the FSM is IDLE and discard the pending access; no cache request is re-issued by this block.
REQ-028 SHALL hold combinational cache outputs as pure functions of inputs during reset.

Verification
REQ-029 LB addr 0x1003, rdata 0x000000F0 (SWAP_ENDIAN=1, byte at lane 3 = 0xF0) -> mem_dat=0xFFFFFFF0, DCACHE_addr=0x400, regwr_out=1 next cycle.
REQ-030 SH addr 0x2002, wdata 0x0000BEEF -> DCACHE_be=1100, DCACHE_wdata=0xEFBEEFBE, wen=1.
REQ-031 LW addr 0x10, DCACHE_stall high 3 cycles -> stall_o=1 for 3 cycles, 3 bubbles, then valid mem_dat with regwr_out=1 exactly once.
REQ-032 LH addr 0x0001 -> ren=0, misalign_o=1, regwr_out=0, stall_o=0 even with DCACHE_stall=1.
REQ-033 ALU op rd=5 result 0x1234 -> fwd_valid=1, fwd_rd=5, fwd_data=0x1234; same with rd=0 -> fwd_valid=0.
REQ-034 rst_n pulsed low in WAIT -> all outputs 0, FSM IDLE, stall_o follows inputs only.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: data cache access, load extraction, MEM/WB register, bypass
// Cache request is driven combinationally from the stage inputs; results land in MEM/WB one cycle later.
module mem_access_unit #(
   parameter int BIT_W       = 32,
   parameter bit SWAP_ENDIAN = 1'b1,
   parameter bit FORWARD_EN  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BIT_W-1:0] alu_result_in,
   input  logic [BIT_W-1:0] mem_wdata_in,
   input  logic             memrd_in,
   input  logic             memwr_in,
   input  logic [2:0]       funct3_in,
   input  logic [BIT_W-1:0] PC_plus_4_in,
   input  logic [4:0]       rd_in,
   input  logic             mem2reg_in,
   input  logic             regwr_in,
   output logic [BIT_W-1:0] alu_result_out,
   output logic [BIT_W-1:0] mem_dat,
   output logic [BIT_W-1:0] PC_plus_4_out,
   output logic [4:0]       rd_out,
   output logic             mem2reg_out,
   output logic             regwr_out,
   output logic             stall_o,
   output logic             misalign_o,
   output logic             fwd_valid,
   output logic [4:0]       fwd_rd,
   output logic [BIT_W-1:0] fwd_data,
   input  logic             DCACHE_stall,
   output logic             DCACHE_ren,
   output logic             DCACHE_wen,
   output logic [29:0]      DCACHE_addr,
   output logic [3:0]       DCACHE_be,
   input  logic [31:0]      DCACHE_rdata,
   output logic [31:0]      DCACHE_wdata
);

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t state_q, state_d;

   logic [BIT_W-1:0] alu_result_q, alu_result_d;
   logic [BIT_W-1:0] mem_dat_q, mem_dat_d;
   logic [BIT_W-1:0] pc_plus_4_q, pc_plus_4_d;
   logic [4:0]       rd_q, rd_d;
   logic             mem2reg_q, mem2reg_d;
   logic             regwr_q, regwr_d;
   logic             misalign_q, misalign_d;

   logic [1:0]  addr_lo;
   logic        is_access, misaligned, access_ok, access_bad;
   logic [31:0] rdata_lanes, wdata_rep, load_ext;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   function automatic logic [31:0] swap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   // Size comes from funct3[1:0] for loads and stores alike; 11 is treated as a word.
   always_comb begin
      addr_lo    = alu_result_in[1:0];
      is_access  = memrd_in | memwr_in;
      case (funct3_in[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = addr_lo[0];
         default: misaligned = (addr_lo != 2'b00);
      endcase
      access_ok  = is_access & ~misaligned;
      access_bad = is_access & misaligned;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (access_ok && DCACHE_stall) state_d = ST_WAIT;
         ST_WAIT: if (!DCACHE_stall)             state_d = ST_IDLE;
         default:                                state_d = ST_IDLE;
      endcase
   end

   // Request is identical in IDLE and WAIT; the frozen upstream keeps it stable while stalled.
   always_comb begin
      stall_o     = access_ok & DCACHE_stall;
      DCACHE_ren  = memrd_in & ~misaligned;
      DCACHE_wen  = memwr_in & ~misaligned;
      DCACHE_addr = alu_result_in[BIT_W-1:2];
      DCACHE_be   = 4'b0000;
      wdata_rep   = mem_wdata_in[31:0];
      case (funct3_in[1:0])
         2'b00: begin
            wdata_rep = {4{mem_wdata_in[7:0]}};
            if (DCACHE_wen) DCACHE_be = 4'b0001 << addr_lo;
         end
         2'b01: begin
            wdata_rep = {2{mem_wdata_in[15:0]}};
            if (DCACHE_wen) DCACHE_be = 4'b0011 << addr_lo;
         end
         default: if (DCACHE_wen) DCACHE_be = 4'b1111;
      endcase
      DCACHE_wdata = SWAP_ENDIAN ? swap32(wdata_rep) : wdata_rep;
   end

   always_comb begin
      rdata_lanes = SWAP_ENDIAN ? swap32(DCACHE_rdata) : DCACHE_rdata;
      case (addr_lo)
         2'b00:   lane_byte = rdata_lanes[7:0];
         2'b01:   lane_byte = rdata_lanes[15:8];
         2'b10:   lane_byte = rdata_lanes[23:16];
         default: lane_byte = rdata_lanes[31:24];
      endcase
      lane_half = addr_lo[1] ? rdata_lanes[31:16] : rdata_lanes[15:0];
      case (funct3_in[1:0])
         2'b00:   load_ext = {{24{~funct3_in[2] & lane_byte[7]}}, lane_byte};
         2'b01:   load_ext = {{16{~funct3_in[2] & lane_half[15]}}, lane_half};
         default: load_ext = rdata_lanes;
      endcase
   end

   // A stalled cycle inserts a bubble; a misaligned access completes with writeback suppressed.
   always_comb begin
      alu_result_d = alu_result_q;
      mem_dat_d    = mem_dat_q;
      pc_plus_4_d  = pc_plus_4_q;
      rd_d         = rd_q;
      mem2reg_d    = 1'b0;
      regwr_d      = 1'b0;
      misalign_d   = 1'b0;
      if (!stall_o) begin
         alu_result_d = alu_result_in;
         mem_dat_d    = load_ext;
         pc_plus_4_d  = PC_plus_4_in;
         rd_d         = rd_in;
         mem2reg_d    = mem2reg_in;
         regwr_d      = regwr_in & ~access_bad;
         misalign_d   = access_bad;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_result_q <= '0;
         mem_dat_q    <= '0;
         pc_plus_4_q  <= '0;
         rd_q         <= '0;
         mem2reg_q    <= 1'b0;
         regwr_q      <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         alu_result_q <= alu_result_d;
         mem_dat_q    <= mem_dat_d;
         pc_plus_4_q  <= pc_plus_4_d;
         rd_q         <= rd_d;
         mem2reg_q    <= mem2reg_d;
         regwr_q      <= regwr_d;
         misalign_q   <= misalign_d;
      end
   end

   assign alu_result_out = alu_result_q;
   assign mem_dat        = mem_dat_q;
   assign PC_plus_4_out  = pc_plus_4_q;
   assign rd_out         = rd_q;
   assign mem2reg_out    = mem2reg_q;
   assign regwr_out      = regwr_q;
   assign misalign_o     = misalign_q;

   generate
      if (FORWARD_EN) begin : g_fwd
         assign fwd_valid = regwr_q & (rd_q != 5'd0);
         assign fwd_rd    = rd_q;
         assign fwd_data  = mem2reg_q ? mem_dat_q : alu_result_q;
      end else begin : g_no_fwd
         assign fwd_valid = 1'b0;
         assign fwd_rd    = 5'd0;
         assign fwd_data  = '0;
      end
   endgenerate

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
// Inputs change 1 time unit after a rising edge; outputs are sampled well clear of the edges.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] alu_result_in, mem_wdata_in, PC_plus_4_in;
   logic        memrd_in, memwr_in, mem2reg_in, regwr_in;
   logic [2:0]  funct3_in;
   logic [4:0]  rd_in;
   logic [31:0] alu_result_out, mem_dat, PC_plus_4_out, fwd_data;
   logic [4:0]  rd_out, fwd_rd;
   logic        mem2reg_out, regwr_out, stall_o, misalign_o, fwd_valid;
   logic        DCACHE_stall, DCACHE_ren, DCACHE_wen;
   logic [29:0] DCACHE_addr;
   logic [3:0]  DCACHE_be;
   logic [31:0] DCACHE_rdata, DCACHE_wdata;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.BIT_W(32), .SWAP_ENDIAN(1'b1), .FORWARD_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_result_in(alu_result_in), .mem_wdata_in(mem_wdata_in),
      .memrd_in(memrd_in), .memwr_in(memwr_in), .funct3_in(funct3_in),
      .PC_plus_4_in(PC_plus_4_in), .rd_in(rd_in), .mem2reg_in(mem2reg_in), .regwr_in(regwr_in),
      .alu_result_out(alu_result_out), .mem_dat(mem_dat), .PC_plus_4_out(PC_plus_4_out),
      .rd_out(rd_out), .mem2reg_out(mem2reg_out), .regwr_out(regwr_out),
      .stall_o(stall_o), .misalign_o(misalign_o),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .DCACHE_stall(DCACHE_stall), .DCACHE_ren(DCACHE_ren), .DCACHE_wen(DCACHE_wen),
      .DCACHE_addr(DCACHE_addr), .DCACHE_be(DCACHE_be),
      .DCACHE_rdata(DCACHE_rdata), .DCACHE_wdata(DCACHE_wdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic m2r, input logic rw);
      memrd_in = rd_en; memwr_in = wr_en; funct3_in = f3;
      alu_result_in = addr; mem_wdata_in = wdata; DCACHE_rdata = rdata;
      rd_in = rd; mem2reg_in = m2r; regwr_in = rw;
      PC_plus_4_in = addr + 32'd4;
   endtask

   initial begin
      rst_n = 1'b0; DCACHE_stall = 1'b0;
      set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      #12;
      chk("rst_regwr", {31'd0, regwr_out}, 32'd0);
      chk("rst_mem_dat", mem_dat, 32'd0);
      chk("rst_alu_out", alu_result_out, 32'd0);
      chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      tick();

      // LB from lane 3, sign-extended
      set_op(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h0000_00F0, 5'd7, 1'b1, 1'b1);
      #1;
      chk("lb_addr", {2'b00, DCACHE_addr}, 32'h400);
      chk("lb_ren", {31'd0, DCACHE_ren}, 32'd1);
      chk("lb_be", {28'd0, DCACHE_be}, 32'h0);
      chk("lb_stall", {31'd0, stall_o}, 32'd0);
      tick();
      chk("lb_mem_dat", mem_dat, 32'hFFFF_FFF0);
      chk("lb_regwr", {31'd0, regwr_out}, 32'd1);
      chk("lb_fwd_data", fwd_data, 32'hFFFF_FFF0);
      chk("lb_fwd_rd", {27'd0, fwd_rd}, 32'd7);
      chk("lb_pc4", PC_plus_4_out, 32'h1007);

      set_op(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 32'h0000_00F0, 5'd7, 1'b1, 1'b1);
      tick();
      chk("lbu_mem_dat", mem_dat, 32'h0000_00F0);

      // un-swapped word 0x80FE0000: upper half 0x80FE
      set_op(1'b1, 1'b0, 3'b001, 32'h0002, 32'h0, 32'h0000_FE80, 5'd8, 1'b1, 1'b1);
      tick();
      chk("lh_mem_dat", mem_dat, 32'hFFFF_80FE);
      set_op(1'b1, 1'b0, 3'b101, 32'h0002, 32'h0, 32'h0000_FE80, 5'd8, 1'b1, 1'b1);
      tick();
      chk("lhu_mem_dat", mem_dat, 32'h0000_80FE);

      set_op(1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000_BEEF, 32'h0, 5'd0, 1'b0, 1'b0);
      #1;
      chk("sh_be", {28'd0, DCACHE_be}, 32'b1100);
      chk("sh_wdata", DCACHE_wdata, 32'hEFBE_EFBE);
      chk("sh_wen", {31'd0, DCACHE_wen}, 32'd1);
      chk("sh_ren", {31'd0, DCACHE_ren}, 32'd0);
      tick();

      set_op(1'b0, 1'b1, 3'b000, 32'h2001, 32'h1234_56A5, 32'h0, 5'd0, 1'b0, 1'b0);
      #1;
      chk("sb_be", {28'd0, DCACHE_be}, 32'b0010);
      chk("sb_wdata", DCACHE_wdata, 32'hA5A5_A5A5);
      tick();

      set_op(1'b0, 1'b1, 3'b010, 32'h3000, 32'h1122_3344, 32'h0, 5'd0, 1'b0, 1'b0);
      #1;
      chk("sw_be", {28'd0, DCACHE_be}, 32'b1111);
      chk("sw_wdata", DCACHE_wdata, 32'h4433_2211);
      tick();

      set_op(1'b0, 1'b1, 3'b010, 32'h3002, 32'h1122_3344, 32'h0, 5'd0, 1'b0, 1'b0);
      #1;
      chk("sw_mis_wen", {31'd0, DCACHE_wen}, 32'd0);
      chk("sw_mis_be", {28'd0, DCACHE_be}, 32'd0);
      tick();
      chk("sw_mis_flag", {31'd0, misalign_o}, 32'd1);

      // misaligned load outranks a cache stall
      DCACHE_stall = 1'b1;
      set_op(1'b1, 1'b0, 3'b001, 32'h0001, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1);
      #1;
      chk("lh_mis_ren", {31'd0, DCACHE_ren}, 32'd0);
      chk("lh_mis_stall", {31'd0, stall_o}, 32'd0);
      tick();
      chk("lh_mis_flag", {31'd0, misalign_o}, 32'd1);
      chk("lh_mis_regwr", {31'd0, regwr_out}, 32'd0);

      // LW held off by the cache for three cycles
      set_op(1'b1, 1'b0, 3'b010, 32'h0010, 32'h0, 32'hAABB_CCDD, 5'd3, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("lw_stall_%0d", i), {31'd0, stall_o}, 32'd1);
         tick();
         chk($sformatf("lw_bubble_%0d", i), {31'd0, regwr_out}, 32'd0);
      end
      DCACHE_stall = 1'b0;
      #1;
      chk("lw_stall_drop", {31'd0, stall_o}, 32'd0);
      tick();
      chk("lw_regwr", {31'd0, regwr_out}, 32'd1);
      chk("lw_mem_dat", mem_dat, 32'hDDCC_BBAA);
      set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      tick();
      chk("lw_once", {31'd0, regwr_out}, 32'd0);

      set_op(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h0, 5'd5, 1'b0, 1'b1);
      tick();
      chk("alu_fwd_valid", {31'd0, fwd_valid}, 32'd1);
      chk("alu_fwd_rd", {27'd0, fwd_rd}, 32'd5);
      chk("alu_fwd_data", fwd_data, 32'h1234);
      set_op(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
      tick();
      chk("alu_rd0_fwd", {31'd0, fwd_valid}, 32'd0);

      // reset while waiting on the cache
      DCACHE_stall = 1'b1;
      set_op(1'b1, 1'b0, 3'b010, 32'h0040, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1);
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("wrst_alu_out", alu_result_out, 32'd0);
      chk("wrst_pc4", PC_plus_4_out, 32'd0);
      chk("wrst_rd_out", {27'd0, rd_out}, 32'd0);
      chk("wrst_stall_in", {31'd0, stall_o}, 32'd1);
      chk("wrst_addr", {2'b00, DCACHE_addr}, 32'h10);
      DCACHE_stall = 1'b0;
      #1;
      chk("wrst_stall_drop", {31'd0, stall_o}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      tick();
      chk("wrst_after_regwr", {31'd0, regwr_out}, 32'd0);
      chk("wrst_after_stall", {31'd0, stall_o}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
